// File: rtl/rsa_cmd_pkg.sv
// rtl/rsa_cmd_pkg.sv - shared widths, command codes, FSM states and command decoder
package rsa_cmd_pkg;

  localparam int DEF_DW = 1024;
  localparam int DEF_TW = 10;

  // COMPUTE word layout: t in the top bits, zero code field below
  localparam int CMD_T_MSB    = 31;
  localparam int CMD_T_LSB    = 22;
  localparam int CMD_CODE_MSB = 21;

  localparam logic [21:0] CMD_COMPUTE      = 22'd0;
  localparam logic [21:0] CMD_READ_X       = 22'd1;
  localparam logic [21:0] CMD_WRITE_RESULT = 22'd2;
  localparam logic [21:0] CMD_READ_E       = 22'd3;
  localparam logic [21:0] CMD_WRITE_X      = 22'd4;
  localparam logic [21:0] CMD_READ_R       = 22'd5;
  localparam logic [21:0] CMD_WRITE_E      = 22'd6;
  localparam logic [21:0] CMD_READ_R2      = 22'd7;
  localparam logic [21:0] CMD_WRITE_M      = 22'd8;
  localparam logic [21:0] CMD_READ_M       = 22'd9;
  localparam logic [21:0] CMD_WRITE_R      = 22'd10;
  localparam logic [21:0] CMD_WRITE_R2     = 22'd12;

  // operand bank select encoding
  localparam logic [2:0] OP_SEL_X  = 3'd0;
  localparam logic [2:0] OP_SEL_E  = 3'd1;
  localparam logic [2:0] OP_SEL_M  = 3'd2;
  localparam logic [2:0] OP_SEL_R  = 3'd3;
  localparam logic [2:0] OP_SEL_R2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_TX,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_RX,
    K_TX,
    K_COMPUTE
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] sel;
    logic       use_result;
  } cmd_dec_t;

  // Map the low code field to an action; unknown codes yield K_NONE
  function automatic cmd_dec_t decode_cmd(input logic [21:0] code);
    cmd_dec_t d;
    d.kind       = K_NONE;
    d.sel        = OP_SEL_X;
    d.use_result = 1'b0;
    case (code)
      CMD_COMPUTE:      d.kind = K_COMPUTE;
      CMD_READ_X:       begin d.kind = K_RX; d.sel = OP_SEL_X;  end
      CMD_READ_E:       begin d.kind = K_RX; d.sel = OP_SEL_E;  end
      CMD_READ_R:       begin d.kind = K_RX; d.sel = OP_SEL_R;  end
      CMD_READ_R2:      begin d.kind = K_RX; d.sel = OP_SEL_R2; end
      CMD_READ_M:       begin d.kind = K_RX; d.sel = OP_SEL_M;  end
      CMD_WRITE_RESULT: begin d.kind = K_TX; d.use_result = 1'b1; end
      CMD_WRITE_X:      begin d.kind = K_TX; d.sel = OP_SEL_X;  end
      CMD_WRITE_E:      begin d.kind = K_TX; d.sel = OP_SEL_E;  end
      CMD_WRITE_M:      begin d.kind = K_TX; d.sel = OP_SEL_M;  end
      CMD_WRITE_R:      begin d.kind = K_TX; d.sel = OP_SEL_R;  end
      CMD_WRITE_R2:     begin d.kind = K_TX; d.sel = OP_SEL_R2; end
      default:          d.kind = K_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rsa_cmd_interface_if.sv
// rtl/rsa_cmd_interface_if.sv - ARM<->FPGA command/data/done signal bundle
interface rsa_cmd_interface_if #(
  parameter int DW = rsa_cmd_pkg::DEF_DW
);
  logic [31:0]   arm_to_fpga_cmd;
  logic          arm_to_fpga_cmd_valid;
  logic          arm_to_fpga_done;
  logic          arm_to_fpga_done_read;
  logic          arm_to_fpga_data_valid;
  logic          arm_to_fpga_data_ready;
  logic [DW-1:0] arm_to_fpga_data;
  logic          fpga_to_arm_data_valid;
  logic          fpga_to_arm_data_ready;
  logic [DW-1:0] fpga_to_arm_data;

  // ARM side
  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    input  arm_to_fpga_done, arm_to_fpga_data_ready,
           fpga_to_arm_data_valid, fpga_to_arm_data
  );

  // FPGA responder side
  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
           arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    output arm_to_fpga_done, arm_to_fpga_data_ready,
           fpga_to_arm_data_valid, fpga_to_arm_data
  );
endinterface

// File: rtl/rsa_operand_bank.sv
// rtl/rsa_operand_bank.sv - five operand registers with strobed write and read mux
module rsa_operand_bank
  import rsa_cmd_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [2:0]    i_sel,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_x,
  output logic [DW-1:0] o_e,
  output logic [DW-1:0] o_m,
  output logic [DW-1:0] o_r,
  output logic [DW-1:0] o_r2
);
  logic [DW-1:0] r_x, r_e, r_m, r_r, r_r2;

  // Write the selected operand on the strobe; everything clears on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x  <= '0;
      r_e  <= '0;
      r_m  <= '0;
      r_r  <= '0;
      r_r2 <= '0;
    end else if (i_we) begin
      case (i_sel)
        OP_SEL_X:  r_x  <= i_wdata;
        OP_SEL_E:  r_e  <= i_wdata;
        OP_SEL_M:  r_m  <= i_wdata;
        OP_SEL_R:  r_r  <= i_wdata;
        OP_SEL_R2: r_r2 <= i_wdata;
        default:   ;
      endcase
    end
  end

  // Read mux feeding the outbound stream
  always_comb begin
    o_rdata = '0;
    case (i_sel)
      OP_SEL_X:  o_rdata = r_x;
      OP_SEL_E:  o_rdata = r_e;
      OP_SEL_M:  o_rdata = r_m;
      OP_SEL_R:  o_rdata = r_r;
      OP_SEL_R2: o_rdata = r_r2;
      default:   o_rdata = '0;
    endcase
  end

  assign o_x  = r_x;
  assign o_e  = r_e;
  assign o_m  = r_m;
  assign o_r  = r_r;
  assign o_r2 = r_r2;

endmodule

// File: rtl/rsa_cmd_interface.sv
// rtl/rsa_cmd_interface.sv - RSA command responder FSM (optional CMD_IF_TIMEOUT_EN handshake timeout)
module rsa_cmd_interface
  import rsa_cmd_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int TW = DEF_TW
`ifdef CMD_IF_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic          clk,
  input  logic          reset,
  rsa_cmd_interface_if.slave arm,
  output logic          core_start,
  output logic [TW-1:0] core_t,
  input  logic          core_done,
  input  logic [DW-1:0] core_result,
  output logic [DW-1:0] op_x,
  output logic [DW-1:0] op_e,
  output logic [DW-1:0] op_m,
  output logic [DW-1:0] op_r,
  output logic [DW-1:0] op_r2,
  output logic          error,
  output logic [3:0]    leds
);
  state_e        r_state;
  logic [2:0]    r_sel;
  logic          r_use_result;
  logic          r_done;
  logic          r_data_ready;
  logic          r_tx_valid;
  logic          r_core_start;
  logic [TW-1:0] r_core_t;
  logic [DW-1:0] r_result;

  cmd_dec_t      w_dec;
  logic [TW-1:0] w_cmd_t;
  logic          w_rx_fire;
  logic          w_tx_fire;
  logic [DW-1:0] w_bank_rdata;

  assign w_dec     = decode_cmd(arm.arm_to_fpga_cmd[CMD_CODE_MSB:0]);
  assign w_cmd_t   = TW'(arm.arm_to_fpga_cmd[CMD_T_MSB:CMD_T_LSB]);
  assign w_rx_fire = (r_state == S_RX) && r_data_ready && arm.arm_to_fpga_data_valid;
  assign w_tx_fire = (r_state == S_TX) && r_tx_valid && arm.fpga_to_arm_data_ready;

`ifdef CMD_IF_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] r_tmo_cnt;
  logic           r_error;
  logic           w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;
`else
  assign error = 1'b0;
`endif

  // Bank is written only on an inbound handshake, never during WAIT
  rsa_operand_bank #(.DW(DW)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_rx_fire),
    .i_sel   (r_sel),
    .i_wdata (arm.arm_to_fpga_data),
    .o_rdata (w_bank_rdata),
    .o_x     (op_x),
    .o_e     (op_e),
    .o_m     (op_m),
    .o_r     (op_r),
    .o_r2    (op_r2)
  );

  // Command FSM: decode in IDLE, run one transfer or computation, then hold done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= OP_SEL_X;
      r_use_result <= 1'b0;
      r_done       <= 1'b0;
      r_data_ready <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_core_start <= 1'b0;
      r_core_t     <= '0;
      r_result     <= '0;
`ifdef CMD_IF_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef CMD_IF_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          if (arm.arm_to_fpga_cmd_valid) begin
            r_sel        <= w_dec.sel;
            r_use_result <= w_dec.use_result;
`ifdef CMD_IF_TIMEOUT_EN
            r_error      <= 1'b0;
`endif
            case (w_dec.kind)
              K_RX: begin
                r_state      <= S_RX;
                r_data_ready <= 1'b1;
              end
              K_TX: begin
                r_state    <= S_TX;
                r_tx_valid <= 1'b1;
              end
              K_COMPUTE: begin
                // t==0 is a no-op: skip the core and leave the result alone
                if (w_cmd_t != '0) begin
                  r_state      <= S_START;
                  r_core_start <= 1'b1;
                  r_core_t     <= w_cmd_t;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_RX: begin
          if (w_rx_fire) begin
            r_data_ready <= 1'b0;
            r_state      <= S_DONE;
            r_done       <= 1'b1;
          end
`ifdef CMD_IF_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_data_ready <= 1'b0;
            r_error      <= 1'b1;
            r_state      <= S_DONE;
            r_done       <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_TX: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
          end
`ifdef CMD_IF_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_tx_valid <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            r_result <= core_result;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          // done_read has priority; a command arriving now is dropped
          if (arm.arm_to_fpga_done_read) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arm.arm_to_fpga_done       = r_done;
  assign arm.arm_to_fpga_data_ready = r_data_ready;
  assign arm.fpga_to_arm_data_valid = r_tx_valid;
  // Outbound data is zero outside TX so the bus idles quietly
  assign arm.fpga_to_arm_data       = r_tx_valid ? (r_use_result ? r_result : w_bank_rdata) : '0;

  assign core_start = r_core_start;
  assign core_t     = r_core_t;
  assign leds       = {error,
                       (r_state == S_START) || (r_state == S_WAIT),
                       (r_state == S_RX) || (r_state == S_TX),
                       r_done};

endmodule

// File: tb/tb_rsa_cmd_interface.sv
// tb/tb_rsa_cmd_interface.sv - directed scoreboard bench for rsa_cmd_interface
module tb_rsa_cmd_interface;
  localparam int DW  = 1024;
  localparam int TW  = 10;
  localparam int TMO = 4096;

  localparam logic [DW-1:0] DX  = {16'ha426, {62{16'h5a3c}}, 16'he82c};
  localparam logic [DW-1:0] DE  = DW'(32'h0000d6db);
  localparam logic [DW-1:0] DM  = {8{128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
  localparam logic [DW-1:0] DRR = {8{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
  localparam logic [DW-1:0] DR2 = {8{128'hdead_beef_cafe_f00d_0bad_c0de_1234_abcd}};
  localparam logic [DW-1:0] DRES = {16'h1c1f, {62{16'h7e21}}, 16'h3991};

  logic          clk = 1'b0;
  logic          reset;
  logic          core_start;
  logic [TW-1:0] core_t;
  logic          core_done;
  logic [DW-1:0] core_result;
  logic [DW-1:0] op_x, op_e, op_m, op_r, op_r2;
  logic          error;
  logic [3:0]    leds;

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  logic [DW-1:0] exp_q[$];

  rsa_cmd_interface_if #(.DW(DW)) arm_if ();

  rsa_cmd_interface #(.DW(DW), .TW(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm_if),
    .core_start  (core_start),
    .core_t      (core_t),
    .core_done   (core_done),
    .core_result (core_result),
    .op_x        (op_x),
    .op_e        (op_e),
    .op_m        (op_m),
    .op_r        (op_r),
    .op_r2       (op_r2),
    .error       (error),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) n_starts++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs[95:0], exp[95:0]);
    end
  endtask

  task automatic send_cmd(input logic [31:0] c);
    arm_if.arm_to_fpga_cmd       = c;
    arm_if.arm_to_fpga_cmd_valid = 1'b1;
    tick();
    arm_if.arm_to_fpga_cmd_valid = 1'b0;
  endtask

  task automatic done_ack(input string tag);
    chk({tag, "_done"}, arm_if.arm_to_fpga_done, 1);
    arm_if.arm_to_fpga_done_read = 1'b1;
    tick();
    arm_if.arm_to_fpga_done_read = 1'b0;
    chk({tag, "_done_clr"}, arm_if.arm_to_fpga_done, 0);
  endtask

  // Valid is raised together with the command and held until ready appears
  task automatic rx_op(input string tag, input logic [31:0] c, input logic [DW-1:0] d);
    int n;
    arm_if.arm_to_fpga_data       = d;
    arm_if.arm_to_fpga_data_valid = 1'b1;
    send_cmd(c);
    n = 0;
    while (arm_if.arm_to_fpga_data_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_rdy_lat"}, n, 0);
    tick();
    arm_if.arm_to_fpga_data_valid = 1'b0;
    chk({tag, "_rdy_drop"}, arm_if.arm_to_fpga_data_ready, 0);
    done_ack(tag);
  endtask

  // Expected word comes off the scoreboard once the DUT presents data
  task automatic tx_op(input string tag, input logic [31:0] c, input int hold);
    int n;
    logic [DW-1:0] exp;
    arm_if.fpga_to_arm_data_ready = 1'b0;
    send_cmd(c);
    n = 0;
    while (arm_if.fpga_to_arm_data_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_vld_lat"}, n, 0);
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb_empty obs=%0d exp=>0", tag, exp_q.size());
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_stable"}, arm_if.fpga_to_arm_data, exp);
      tick();
    end
    arm_if.fpga_to_arm_data_ready = 1'b1;
    chk({tag, "_data"}, arm_if.fpga_to_arm_data, exp);
    tick();
    arm_if.fpga_to_arm_data_ready = 1'b0;
    chk({tag, "_vld_drop"}, arm_if.fpga_to_arm_data_valid, 0);
    done_ack(tag);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    core_done = 1'b0;
    core_result = '0;
    arm_if.arm_to_fpga_cmd = '0;
    arm_if.arm_to_fpga_cmd_valid = 1'b0;
    arm_if.arm_to_fpga_done_read = 1'b0;
    arm_if.arm_to_fpga_data_valid = 1'b0;
    arm_if.arm_to_fpga_data = '0;
    arm_if.fpga_to_arm_data_ready = 1'b0;
    tick(); tick(); tick();

    chk("rst_done", arm_if.arm_to_fpga_done, 0);
    chk("rst_ready", arm_if.arm_to_fpga_data_ready, 0);
    chk("rst_txvalid", arm_if.fpga_to_arm_data_valid, 0);
    chk("rst_txdata", arm_if.fpga_to_arm_data, '0);
    chk("rst_start", core_start, 0);
    chk("rst_core_t", core_t, 0);
    chk("rst_op_x", op_x, '0);
    chk("rst_error", error, 0);
    chk("rst_leds", leds, 0);
    reset = 1'b0;
    tick();

    rx_op("read_x", 32'd1, DX);
    chk("op_x", op_x, DX);

    rx_op("read_e", 32'd3, DE);
    chk("op_e", op_e, DE);
    exp_q.push_back(DE);
    tx_op("write_e", 32'd6, 0);

    rx_op("read_m", 32'd9, DM);
    rx_op("read_r", 32'd5, DRR);
    rx_op("read_r2", 32'd7, DR2);
    chk("op_m", op_m, DM);
    chk("op_r", op_r, DRR);
    chk("op_r2", op_r2, DR2);
    exp_q.push_back(DX);
    tx_op("write_x_hold", 32'd4, 3);
    exp_q.push_back(DR2);
    tx_op("write_r2", 32'd12, 0);

    // compute with t=16, plus an ignored command during WAIT
    base = n_starts;
    send_cmd(32'h0400_0000);
    chk("cmp_start", core_start, 1);
    chk("cmp_core_t", core_t, 16);
    chk("cmp_leds_busy", leds, 4'b0100);
    tick();
    chk("cmp_start_pulse", core_start, 0);
    send_cmd(32'd1);
    chk("wait_cmd_ignored", arm_if.arm_to_fpga_data_ready, 0);
    for (int i = 0; i < 46; i++) tick();
    chk("wait_no_done", arm_if.arm_to_fpga_done, 0);
    core_result = DRES;
    core_done   = 1'b1;
    tick();
    core_done   = 1'b0;
    core_result = '0;
    chk("cmp_leds_done", leds, 4'b0001);
    chk("cmp_one_start", n_starts - base, 1);
    chk("wait_op_x_stable", op_x, DX);
    done_ack("compute");
    exp_q.push_back(DRES);
    tx_op("write_result", 32'd2, 0);

    // t == 0: immediate done, no pulse, result untouched
    base = n_starts;
    send_cmd(32'h0000_0000);
    chk("t0_no_start", core_start, 0);
    done_ack("t0");
    chk("t0_no_pulse", n_starts - base, 0);
    exp_q.push_back(DRES);
    tx_op("result_kept", 32'd2, 0);

    // unknown code, then done_read racing a new command
    send_cmd(32'h0000_000B);
    chk("unk_done", arm_if.arm_to_fpga_done, 1);
    chk("unk_op_x", op_x, DX);
    chk("unk_op_e", op_e, DE);
    chk("unk_op_m", op_m, DM);
    chk("unk_op_r", op_r, DRR);
    chk("unk_op_r2", op_r2, DR2);
    arm_if.arm_to_fpga_done_read = 1'b1;
    arm_if.arm_to_fpga_cmd       = 32'd1;
    arm_if.arm_to_fpga_cmd_valid = 1'b1;
    tick();
    arm_if.arm_to_fpga_done_read = 1'b0;
    arm_if.arm_to_fpga_cmd_valid = 1'b0;
    chk("race_done_clr", arm_if.arm_to_fpga_done, 0);
    chk("race_cmd_lost", arm_if.arm_to_fpga_data_ready, 0);
    tick();
    chk("race_idle", leds, 0);

`ifdef CMD_IF_TIMEOUT_EN
    send_cmd(32'd9);
    n = 0;
    while (arm_if.arm_to_fpga_done !== 1'b1 && n < TMO + 20) begin tick(); n++; end
    chk("tmo_latency", n, TMO);
    chk("tmo_error", error, 1);
    chk("tmo_op_m", op_m, DM);
    chk("tmo_leds", leds, 4'b1001);
    done_ack("tmo");
    send_cmd(32'h0000_000B);
    chk("tmo_err_clr", error, 0);
    done_ack("tmo_next");
`endif

    // reset in WAIT, then a stale core_done must do nothing
    send_cmd(32'h0400_0000);
    tick();
    base = n_starts;
    reset = 1'b1;
    #1;
    chk("rw_start", core_start, 0);
    chk("rw_core_t", core_t, 0);
    chk("rw_done", arm_if.arm_to_fpga_done, 0);
    chk("rw_op_x", op_x, '0);
    chk("rw_leds", leds, 0);
    tick(); tick();
    reset = 1'b0;
    core_result = DRES;
    core_done   = 1'b1;
    tick();
    core_done   = 1'b0;
    tick();
    chk("rw_stale_done", arm_if.arm_to_fpga_done, 0);
    chk("rw_no_start", n_starts - base, 0);
    exp_q.push_back('0);
    tx_op("rw_result", 32'd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
